fmab_pack: RTL

- Drain/convert stage for the 4-lane block-floating multiply-accumulator.
- On a start pulse, captures the four lane accumulators (32-bit signed fixed point) and their 10-bit exponents, normalizes and rounds each lane to IEEE-754 binary32, and emits the four results serially on a valid/ready stream.
- Sits between the accumulator outputs and the result writeback path; it is the float-encode end of the accumulator's float-decode/align datapath.

---
 rtl/fmab_pack.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fmab_pack.sv
// rtl/fmab_pack.sv - drains four block-floating lane accumulators as binary32 results
// Capture on start, then per lane: normalize, round, encode, hold on a valid/ready stream.
module fmab_pack #(
  parameter int EXP_ADJ  = 141,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  input  logic [31:0] acc2,
  input  logic [31:0] acc3,
  input  logic [9:0]  exp0,
  input  logic [9:0]  exp1,
  input  logic [9:0]  exp2,
  input  logic [9:0]  exp3,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_lane,
  output logic        out_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic             primed_q, primed_d;
  logic             cap_en, norm_en, out_en;
  logic [3:0][31:0] cap_acc_q;
  logic [3:0][9:0]  cap_exp_q;

  logic             n_sign_q;
  logic [4:0]       n_p_q;
  logic [31:0]      n_mag_q;
  logic [9:0]       n_exp_q;

  logic [31:0]      out_data_q;
  logic [1:0]       out_lane_q;
  logic             out_last_q;

  // The normalize stage runs one lane ahead of the output register, so after
  // the first lane each result only costs one NORM cycle plus its EMIT cycle.
  logic [1:0]  nidx;
  logic [31:0] sel_acc;
  logic [9:0]  sel_exp;
  logic [31:0] mag;
  logic [4:0]  p;
  logic [31:0] nmag;

  always_comb begin
    nidx    = primed_q ? lane_q + 2'd1 : lane_q;
    sel_acc = cap_acc_q[nidx];
    sel_exp = cap_exp_q[nidx];
    mag     = sel_acc[31] ? (~sel_acc + 32'd1) : sel_acc;
    p       = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    nmag = mag << (5'd31 - p);
  end

  logic               round_up;
  logic               carry;
  logic [22:0]        frac;
  logic signed [11:0] e_raw;
  logic signed [11:0] e_rnd;
  logic [31:0]        enc;

  // n_mag_q[31] is the hidden one, so a carry out of the fraction is the
  // carry out of the full 24-bit mantissa and leaves frac wrapped to 1.0.
  always_comb begin
    round_up = ROUND_EN && ((n_mag_q[7:0] > 8'h80) ||
                            ((n_mag_q[7:0] == 8'h80) && n_mag_q[8]));
    {carry, frac} = {1'b0, n_mag_q[30:8]} + 24'(round_up);
    e_raw = $signed({2'b00, n_exp_q}) + $signed({7'b0, n_p_q}) - 12'(EXP_ADJ);
    e_rnd = e_raw + $signed({11'b0, carry});
    if ((n_exp_q == 10'd0) || !n_mag_q[31]) begin
      enc = 32'h0000_0000;
    end else if (e_rnd <= 12'sd0) begin
      enc = {n_sign_q, 31'b0};
    end else if (e_rnd >= 12'sd255) begin
      enc = {n_sign_q, 8'hFF, 23'b0};
    end else begin
      enc = {n_sign_q, e_rnd[7:0], frac};
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    primed_d = primed_q;
    cap_en   = 1'b0;
    norm_en  = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cap_en   = 1'b1;
          lane_d   = 2'd0;
          primed_d = 1'b0;
          state_d  = S_NORM;
        end
      end
      S_NORM: begin
        norm_en = 1'b1;
        if (primed_q) begin
          out_en  = 1'b1;
          state_d = S_EMIT;
        end else begin
          primed_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (lane_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            lane_d  = lane_q + 2'd1;
            state_d = S_NORM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      primed_q   <= 1'b0;
      cap_acc_q  <= '0;
      cap_exp_q  <= '0;
      n_sign_q   <= 1'b0;
      n_p_q      <= 5'd0;
      n_mag_q    <= 32'd0;
      n_exp_q    <= 10'd0;
      out_data_q <= 32'd0;
      out_lane_q <= 2'd0;
      out_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      primed_q <= primed_d;
      if (cap_en) begin
        cap_acc_q <= {acc3, acc2, acc1, acc0};
        cap_exp_q <= {exp3, exp2, exp1, exp0};
      end
      if (norm_en) begin
        n_sign_q <= sel_acc[31];
        n_p_q    <= p;
        n_mag_q  <= nmag;
        n_exp_q  <= sel_exp;
      end
      if (out_en) begin
        out_data_q <= enc;
        out_lane_q <= lane_q;
        out_last_q <= (lane_q == 2'd3);
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;

endmodule
